// File: rtl/cpu_ahb_lane_adapter.sv
// ============================================================================
// cpu_ahb_lane_adapter - 32-bit CPU AHB-Lite master to 32/64-bit bus lane adapter
// Rev 1.0
// ============================================================================
`default_nettype none

module cpu_ahb_lane_adapter #(
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16,
  parameter int ALIGN_MODE = 0
) (
  input  logic              cpu_clk,
  input  logic              pad_cpu_rst_b,
  input  logic              cnt_clr,
  input  logic [31:0]       m_haddr,
  input  logic [1:0]        m_htrans,
  input  logic              m_hwrite,
  input  logic [2:0]        m_hsize,
  input  logic [31:0]       m_hwdata,
  output logic [31:0]       m_hrdata,
  output logic              m_hready,
  output logic              m_hresp,
  output logic [31:0]       s_haddr,
  output logic [1:0]        s_htrans,
  output logic              s_hwrite,
  output logic [2:0]        s_hsize,
  output logic [DATA_W-1:0] s_hwdata,
  input  logic [DATA_W-1:0] s_hrdata,
  input  logic              s_hready,
  input  logic [1:0]        s_hresp,
  output logic              dphase_busy,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int LANE_BITS = $clog2(DATA_W / 8);
  localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [LANE_BITS-1:0] r_cap_addr;
  logic [1:0]           r_cap_size;
  logic                 r_cap_write;
  logic                 r_cap_bad;
  logic [CNT_W-1:0]     r_rd_cnt, r_wr_cnt, r_err_cnt;
  logic                 r_misalign;

  logic                 w_err;
  logic                 w_accept;
  logic                 w_bad;
  logic                 w_inc_rd, w_inc_wr, w_inc_err;
  logic [DATA_W-1:0]    w_src;
  logic [31:0]          w_mask;
  logic [31:0]          w_src32;
  logic [31:0]          w_aligned;
  logic                 w_unused_resp;

  assign w_err         = s_hresp[0];
  assign w_unused_resp = s_hresp[1];

  assign s_haddr  = m_haddr;
  assign s_hwrite = m_hwrite;
  assign s_hsize  = m_hsize;
  assign s_hwdata = {(DATA_W/32){m_hwdata}};
  assign m_hready = s_hready;
  assign m_hresp  = w_err;

  // Suppress the next address while the first cycle of an ERROR is on the bus
  // and throughout the second cycle, so the cancelled transfer never issues.
  assign s_htrans = ((r_state == ST_DATA && w_err && !s_hready) || r_state == ST_ERR1)
                    ? 2'b00 : m_htrans;

  assign w_accept = s_htrans[1] & s_hready & (r_state != ST_ERR1);
  assign w_bad    = (m_hsize > 3'd2)
                  | ((m_hsize == 3'd1) & m_haddr[0])
                  | ((m_hsize == 3'd2) & (|m_haddr[1:0]));

  always_ff @(posedge cpu_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_inc_rd    = 1'b0;
    w_inc_wr    = 1'b0;
    w_inc_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (w_err && !s_hready) begin
          w_state_nxt = ST_ERR1;
        end else if (s_hready) begin
          w_inc_err   = w_err;
          w_inc_rd    = !w_err && !r_cap_write;
          w_inc_wr    = !w_err &&  r_cap_write;
          w_state_nxt = w_accept ? ST_DATA : ST_IDLE;
        end
      end
      ST_ERR1: begin
        if (s_hready) begin
          w_inc_err   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      r_cap_addr  <= '0;
      r_cap_size  <= 2'b10;
      r_cap_write <= 1'b0;
      r_cap_bad   <= 1'b0;
    end else if (w_accept) begin
      r_cap_addr  <= m_haddr[LANE_BITS-1:0];
      r_cap_size  <= m_hsize[1:0];
      r_cap_write <= m_hwrite;
      r_cap_bad   <= w_bad;
    end
  end

  // Clear wins over any same-cycle increment or flag set.
  always_ff @(posedge cpu_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
      r_err_cnt  <= '0;
      r_misalign <= 1'b0;
    end else if (cnt_clr) begin
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
      r_err_cnt  <= '0;
      r_misalign <= 1'b0;
    end else begin
      if (w_inc_rd  && (r_rd_cnt  != '1)) r_rd_cnt  <= r_rd_cnt  + c_one;
      if (w_inc_wr  && (r_wr_cnt  != '1)) r_wr_cnt  <= r_wr_cnt  + c_one;
      if (w_inc_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + c_one;
      if (w_accept && w_bad)              r_misalign <= 1'b1;
    end
  end

  assign w_src   = s_hrdata >> {r_cap_addr, 3'b000};
  assign w_src32 = w_src[31:0] & w_mask;

  always_comb begin
    w_mask = 32'hFFFF_FFFF;
    case (r_cap_size)
      2'd0:    w_mask = 32'h0000_00FF;
      2'd1:    w_mask = 32'h0000_FFFF;
      default: w_mask = 32'hFFFF_FFFF;
    endcase
  end

  generate
    if (ALIGN_MODE == 0) begin : g_align_lane
      assign w_aligned = w_src32 << {r_cap_addr[1:0], 3'b000};
    end else begin : g_align_right
      assign w_aligned = w_src32;
    end
  endgenerate

  assign m_hrdata = (r_cap_bad || r_cap_write || (r_state == ST_IDLE) || w_err)
                    ? 32'h0 : w_aligned;

  assign dphase_busy  = (r_state != ST_IDLE);
  assign misalign_err = r_misalign;
  assign rd_cnt       = r_rd_cnt;
  assign wr_cnt       = r_wr_cnt;
  assign err_cnt      = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cpu_ahb_lane_adapter.sv
// ============================================================================
// tb_cpu_ahb_lane_adapter - scoreboard bench, 32-bit/lane-aligned and 64-bit/right-justified instances
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cpu_ahb_lane_adapter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cnt_clr;
  logic [31:0] m_haddr;
  logic [1:0]  m_htrans;
  logic        m_hwrite;
  logic [2:0]  m_hsize;
  logic [31:0] m_hwdata;
  logic [31:0] s_hrdata32;
  logic [63:0] s_hrdata64;
  logic        s_hready;
  logic [1:0]  s_hresp;

  logic [31:0] m_hrdata_a, s_haddr_a, s_hwdata_a;
  logic        m_hready_a, m_hresp_a, s_hwrite_a, busy_a, mis_a;
  logic [1:0]  s_htrans_a;
  logic [2:0]  s_hsize_a;
  logic [15:0] rd_a, wr_a, err_a;

  logic [31:0] m_hrdata_b, s_haddr_b;
  logic [63:0] s_hwdata_b;
  logic        m_hready_b, m_hresp_b, s_hwrite_b, busy_b, mis_b;
  logic [1:0]  s_htrans_b;
  logic [2:0]  s_hsize_b;
  logic [3:0]  rd_b, wr_b, err_b;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       nm;
    logic [31:0] e32;
    logic [31:0] e64;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  cpu_ahb_lane_adapter #(.DATA_W(32), .CNT_W(16), .ALIGN_MODE(0)) u_dut_a (
    .cpu_clk(clk), .pad_cpu_rst_b(rst_n), .cnt_clr(cnt_clr),
    .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite), .m_hsize(m_hsize),
    .m_hwdata(m_hwdata), .m_hrdata(m_hrdata_a), .m_hready(m_hready_a), .m_hresp(m_hresp_a),
    .s_haddr(s_haddr_a), .s_htrans(s_htrans_a), .s_hwrite(s_hwrite_a), .s_hsize(s_hsize_a),
    .s_hwdata(s_hwdata_a), .s_hrdata(s_hrdata32), .s_hready(s_hready), .s_hresp(s_hresp),
    .dphase_busy(busy_a), .misalign_err(mis_a), .rd_cnt(rd_a), .wr_cnt(wr_a), .err_cnt(err_a)
  );

  cpu_ahb_lane_adapter #(.DATA_W(64), .CNT_W(4), .ALIGN_MODE(1)) u_dut_b (
    .cpu_clk(clk), .pad_cpu_rst_b(rst_n), .cnt_clr(cnt_clr),
    .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite), .m_hsize(m_hsize),
    .m_hwdata(m_hwdata), .m_hrdata(m_hrdata_b), .m_hready(m_hready_b), .m_hresp(m_hresp_b),
    .s_haddr(s_haddr_b), .s_htrans(s_htrans_b), .s_hwrite(s_hwrite_b), .s_hsize(s_hsize_b),
    .s_hwdata(s_hwdata_b), .s_hrdata(s_hrdata64), .s_hready(s_hready), .s_hresp(s_hresp),
    .dphase_busy(busy_b), .misalign_err(mis_b), .rd_cnt(rd_b), .wr_cnt(wr_b), .err_cnt(err_b)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic addr_ph(input logic [31:0] a, input logic [2:0] sz, input logic w);
    m_haddr  = a;
    m_hsize  = sz;
    m_hwrite = w;
    m_htrans = 2'b10;
  endtask

  task automatic push(input string nm, input logic [31:0] e32, input logic [31:0] e64);
    exp_t e;
    e.nm  = nm;
    e.e32 = e32;
    e.e64 = e64;
    sb.push_back(e);
  endtask

  // Read-data monitor: a completing data phase pops one expectation.
  always @(negedge clk) begin
    if (busy_a && s_hready && !s_hresp[0]) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.nm, "_a"}, {32'h0, m_hrdata_a}, {32'h0, e.e32});
        chk({e.nm, "_b"}, {32'h0, m_hrdata_b}, {32'h0, e.e64});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    cnt_clr    = 1'b0;
    m_haddr    = 32'h0000_1234;
    m_htrans   = 2'b00;
    m_hwrite   = 1'b0;
    m_hsize    = 3'd2;
    m_hwdata   = 32'h0;
    s_hrdata32 = 32'h0;
    s_hrdata64 = 64'h0;
    s_hready   = 1'b1;
    s_hresp    = 2'b00;

    step(); step(); settle();
    chk("rst_busy",   {63'h0, busy_a}, 64'd0);
    chk("rst_rd",     {48'h0, rd_a},   64'd0);
    chk("rst_mis",    {63'h0, mis_b},  64'd0);
    chk("rst_hrdata", {32'h0, m_hrdata_a}, 64'd0);
    chk("rst_haddr",  {32'h0, s_haddr_b},  64'h1234);
    rst_n = 1'b1;
    step();

    // byte read @..03
    push("rd_b3", 32'hAA00_0000, 32'h0000_0055);
    addr_ph(32'h103, 3'd0, 1'b0); step();
    m_htrans = 2'b00; s_hrdata32 = 32'hAABB_CCDD; s_hrdata64 = 64'h1122_3344_5566_7788;
    step(); settle();
    chk("rd_cnt1_a", {48'h0, rd_a}, 64'd1);
    chk("rd_cnt1_b", {60'h0, rd_b}, 64'd1);
    chk("idle1",     {63'h0, busy_a}, 64'd0);

    // halfword read @..06
    push("rd_h6", 32'hAABB_0000, 32'h0000_1122);
    addr_ph(32'h106, 3'd1, 1'b0); step();
    m_htrans = 2'b00;
    step(); settle();
    chk("rd_cnt2_a", {48'h0, rd_a}, 64'd2);

    // word write, replicated on the 64-bit bus
    push("wr_w", 32'h0, 32'h0);
    addr_ph(32'h110, 3'd2, 1'b1); step();
    m_htrans = 2'b00; m_hwrite = 1'b0; m_hwdata = 32'hDEAD_BEEF; settle();
    chk("hwdata_a", {32'h0, s_hwdata_a}, 64'h0000_0000_DEAD_BEEF);
    chk("hwdata_b", s_hwdata_b, 64'hDEAD_BEEF_DEAD_BEEF);
    step(); settle();
    chk("wr_cnt_a", {48'h0, wr_a}, 64'd1);
    chk("wr_cnt_b", {60'h0, wr_b}, 64'd1);

    cnt_clr = 1'b1; step(); cnt_clr = 1'b0; settle();
    chk("clr_rd", {48'h0, rd_a}, 64'd0);
    chk("clr_wr", {48'h0, wr_a}, 64'd0);

    // back-to-back, two wait states on the first
    push("b2b_w", 32'h1234_5678, 32'h1234_5678);
    push("b2b_b", 32'h0000_DE00, 32'h0000_00DE);
    addr_ph(32'h120, 3'd2, 1'b0); step();
    s_hready = 1'b0; addr_ph(32'h121, 3'd0, 1'b0); settle();
    chk("b2b_wait1", {63'h0, busy_a}, 64'd1);
    step(); settle();
    chk("b2b_wait2", {63'h0, busy_a}, 64'd1);
    chk("b2b_htrans", {62'h0, s_htrans_a}, 64'd2);
    step();
    s_hready = 1'b1; s_hrdata32 = 32'h1234_5678; s_hrdata64 = 64'hCAFE_F00D_1234_5678; settle();
    chk("b2b_busy3", {63'h0, busy_a}, 64'd1);
    step();
    m_htrans = 2'b00; s_hrdata32 = 32'h9ABC_DEF0; s_hrdata64 = 64'h1357_9BDF_9ABC_DEF0; settle();
    chk("b2b_busy_between", {63'h0, busy_b}, 64'd1);
    step(); settle();
    chk("b2b_rd_a", {48'h0, rd_a}, 64'd2);
    chk("b2b_rd_b", {60'h0, rd_b}, 64'd2);
    chk("b2b_idle", {63'h0, busy_a}, 64'd0);

    // two-cycle ERROR with the next NONSEQ pending
    addr_ph(32'h130, 3'd2, 1'b0); step();
    s_hready = 1'b0; s_hresp = 2'b01; addr_ph(32'h140, 3'd2, 1'b0); settle();
    chk("err1_htrans_a", {62'h0, s_htrans_a}, 64'd0);
    chk("err1_htrans_b", {62'h0, s_htrans_b}, 64'd0);
    chk("err1_hrdata",   {32'h0, m_hrdata_a}, 64'd0);
    chk("err1_hresp",    {63'h0, m_hresp_a},  64'd1);
    step();
    s_hready = 1'b1; settle();
    chk("err2_htrans", {62'h0, s_htrans_a}, 64'd0);
    chk("err2_hrdata", {32'h0, m_hrdata_b}, 64'd0);
    chk("err2_busy",   {63'h0, busy_a}, 64'd1);
    chk("err2_cnt0",   {48'h0, err_a}, 64'd0);
    step();
    m_htrans = 2'b00; s_hresp = 2'b00; settle();
    chk("err_drop_busy", {63'h0, busy_a}, 64'd0);
    chk("err_cnt_a",     {48'h0, err_a}, 64'd1);
    chk("err_cnt_b",     {60'h0, err_b}, 64'd1);
    chk("err_rd_same",   {48'h0, rd_a},  64'd2);

    // misaligned word
    push("mis_w2", 32'h0, 32'h0);
    addr_ph(32'h102, 3'd2, 1'b0); step();
    m_htrans = 2'b00; s_hrdata32 = 32'hFFFF_FFFF; s_hrdata64 = 64'hFFFF_FFFF_FFFF_FFFF; settle();
    chk("mis_a", {63'h0, mis_a}, 64'd1);
    chk("mis_b", {63'h0, mis_b}, 64'd1);
    step();

    // clear coinciding with a completion
    push("clr_rd", 32'h0000_00A5, 32'h0000_00A5);
    addr_ph(32'h200, 3'd0, 1'b0); step();
    m_htrans = 2'b00; s_hrdata32 = 32'h0000_00A5; s_hrdata64 = 64'h0000_0000_0000_00A5; cnt_clr = 1'b1;
    step(); cnt_clr = 1'b0; settle();
    chk("clr_cmp_rd_a", {48'h0, rd_a},  64'd0);
    chk("clr_cmp_rd_b", {60'h0, rd_b},  64'd0);
    chk("clr_cmp_mis",  {63'h0, mis_a}, 64'd0);
    chk("clr_cmp_err",  {48'h0, err_a}, 64'd0);

    // 17 pipelined reads: 4-bit counter saturates at 0xF
    s_hrdata32 = 32'h0F0F_0F0F; s_hrdata64 = 64'h0000_0000_0F0F_0F0F;
    for (int i = 0; i < 17; i++) begin
      push("sat", 32'h0F0F_0F0F, 32'h0F0F_0F0F);
      addr_ph(32'h300, 3'd2, 1'b0);
      step();
    end
    m_htrans = 2'b00; step(); settle();
    chk("sat_rd_a", {48'h0, rd_a}, 64'd17);
    chk("sat_rd_b", {60'h0, rd_b}, 64'hF);

    // asynchronous reset in the middle of a data phase
    addr_ph(32'h400, 3'd2, 1'b0); step();
    m_htrans = 2'b00; s_hready = 1'b0; #1;
    chk("pre_rst_hrdata", {32'h0, m_hrdata_a}, 64'h0F0F_0F0F);
    rst_n = 1'b0; #1;
    chk("mrst_busy",   {63'h0, busy_a}, 64'd0);
    chk("mrst_rd_a",   {48'h0, rd_a}, 64'd0);
    chk("mrst_rd_b",   {60'h0, rd_b}, 64'd0);
    chk("mrst_hrdata", {32'h0, m_hrdata_a}, 64'd0);
    m_haddr = 32'h0000_55AA; #1;
    chk("mrst_haddr",  {32'h0, s_haddr_b}, 64'h55AA);
    step(); rst_n = 1'b1; s_hready = 1'b1;
    step(); settle();
    chk("post_rst_busy", {63'h0, busy_b}, 64'd0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
